// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Consumers: pipe_hazard_ctrl (FSM state, defaults) and hazard_detect.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_e;

  localparam int DEF_REG_W       = 5;
  localparam int DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never creates a dependency).
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             lu_hazard_o
);

  logic rs1Hit;
  logic rs2Hit;

  assign rs1Hit      = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2Hit      = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  assign lu_hazard_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1Hit || rs2Hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory handshake FSM with
// timeout watchdog, plus branch/load-use priority mux. HAZARD_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int REG_W       = DEF_REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_br_taken,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             err,
  output logic [31:0]      perf_mem_stall,
  output logic [31:0]      perf_lu_stall,
  output logic [31:0]      perf_flush
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  hz_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             luHazard;
  logic             memStall;

  hazard_detect #(.REG_W(REG_W)) u_detect (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .lu_hazard_o   (luHazard)
  );

  assign dmem_req = !rst && (((state_q == IDLE) && mem_access) || (state_q == WAIT));
  assign memStall = dmem_req && !dmem_ack;
  assign err      = err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memStall) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state_q <= IDLE;
          end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT))) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ERR:     err_q   <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A frozen or stalled pipeline holds branch/load-use requests until it moves again.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_flush = 1'b0;
    if (rst || (state_q == ERR)) begin
      pc_en = 1'b0;
    end else if (memStall) begin
      memwb_flush = 1'b1;
    end else if (ex_br_taken) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (luHazard) begin
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      idex_flush = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perfMem_q;
  logic [31:0] perfLu_q;
  logic [31:0] perfFlush_q;
  logic        brApplied;
  logic        luApplied;

  assign brApplied = !rst && (state_q != ERR) && !memStall && ex_br_taken;
  assign luApplied = !rst && (state_q != ERR) && !memStall && !ex_br_taken && luHazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      perfMem_q   <= '0;
      perfLu_q    <= '0;
      perfFlush_q <= '0;
    end else begin
      if (memStall)  perfMem_q   <= perfMem_q + 32'd1;
      if (luApplied) perfLu_q    <= perfLu_q + 32'd1;
      if (brApplied) perfFlush_q <= perfFlush_q + 32'd1;
    end
  end

  assign perf_mem_stall = rst ? '0 : perfMem_q;
  assign perf_lu_stall  = rst ? '0 : perfLu_q;
  assign perf_flush     = rst ? '0 : perfFlush_q;
`else
  assign perf_mem_stall = '0;
  assign perf_lu_stall  = '0;
  assign perf_flush     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); perf expectations
// follow HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic       memAccess;
    logic       ack;
    logic       brTaken;
    logic       exMemRead;
    logic [4:0] exRd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       useRs1;
    logic       useRs2;
  } stim_t;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] pm;
    logic [31:0] pl;
    logic [31:0] pf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  idRs1 = '0, idRs2 = '0, exRd = '0;
  logic        idUseRs1 = 1'b0, idUseRs2 = 1'b0, exMemRead = 1'b0;
  logic        exBrTaken = 1'b0, memAccess = 1'b0, dmemAck = 1'b0;
  logic        dmemReq, pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbFlush, errOut;
  logic [31:0] perfMem, perfLu, perfFlush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .REG_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (idRs1),
    .id_rs2         (idRs2),
    .id_use_rs1     (idUseRs1),
    .id_use_rs2     (idUseRs2),
    .ex_mem_read    (exMemRead),
    .ex_rd          (exRd),
    .ex_br_taken    (exBrTaken),
    .mem_access     (memAccess),
    .dmem_ack       (dmemAck),
    .dmem_req       (dmemReq),
    .pc_en          (pcEn),
    .ifid_en        (ifidEn),
    .ifid_flush     (ifidFlush),
    .idex_en        (idexEn),
    .idex_flush     (idexFlush),
    .exmem_en       (exmemEn),
    .memwb_flush    (memwbFlush),
    .err            (errOut),
    .perf_mem_stall (perfMem),
    .perf_lu_stall  (perfLu),
    .perf_flush     (perfFlush)
  );

  exp_t        expQ[$];
  int          checkCount = 0;
  int          failCount  = 0;
  int          mState = 0;
  int          mCnt   = 0;
  logic        mErr   = 1'b0;
  logic [31:0] mPm = '0, mPl = '0, mPf = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic stim_t mkStim(logic r, logic ma, logic ak, logic br, logic emr,
                                   logic [4:0] rd, logic [4:0] s1, logic [4:0] s2,
                                   logic u1, logic u2);
    stim_t s;
    s.rst = r; s.memAccess = ma; s.ack = ak; s.brTaken = br; s.exMemRead = emr;
    s.exRd = rd; s.rs1 = s1; s.rs2 = s2; s.useRs1 = u1; s.useRs2 = u2;
    return s;
  endfunction

  // One clock of stimulus: drive, predict, queue, then compare at the negedge.
  task automatic applyStimulus(input stim_t s, input string tag);
    exp_t e;
    exp_t got;
    logic req, stall, lu, brApp, luApp;
    logic eReq, ePc, eIfid, eIfidF, eIdex, eIdexF, eExmem, eMemwbF, eErr;
    @(posedge clk);
    #1;
    rst = s.rst; memAccess = s.memAccess; dmemAck = s.ack; exBrTaken = s.brTaken;
    exMemRead = s.exMemRead; exRd = s.exRd; idRs1 = s.rs1; idRs2 = s.rs2;
    idUseRs1 = s.useRs1; idUseRs2 = s.useRs2;

    req   = !s.rst && ((mState == 0 && s.memAccess) || mState == 1);
    stall = req && !s.ack;
    lu    = s.exMemRead && (s.exRd != 5'd0) &&
            ((s.useRs1 && s.rs1 == s.exRd) || (s.useRs2 && s.rs2 == s.exRd));
    {ePc, eIfid, eIfidF, eIdex, eIdexF, eExmem, eMemwbF} = 7'b0;
    brApp = 1'b0; luApp = 1'b0;
    eReq = req;
    eErr = !s.rst && mErr;
    if (s.rst || mState == 2) begin
      eReq = 1'b0;
    end else if (stall) begin
      eMemwbF = 1'b1;
    end else if (s.brTaken) begin
      {ePc, eIfid, eIdex, eExmem, eIfidF, eIdexF} = 6'b111111;
      brApp = 1'b1;
    end else if (lu) begin
      {eIdex, eExmem, eIdexF} = 3'b111;
      luApp = 1'b1;
    end else begin
      {ePc, eIfid, eIdex, eExmem} = 4'b1111;
    end
    e.ctrl = {eReq, ePc, eIfid, eIfidF, eIdex, eIdexF, eExmem, eMemwbF, eErr};
    e.pm   = (s.rst || !PERF_EN) ? 32'd0 : mPm;
    e.pl   = (s.rst || !PERF_EN) ? 32'd0 : mPl;
    e.pf   = (s.rst || !PERF_EN) ? 32'd0 : mPf;
    expQ.push_back(e);

    @(negedge clk);
    if (expQ.size() == 0) begin
      checkOutput({tag, ":queue"}, 32'd0, 32'd1);
    end else begin
      got = expQ.pop_front();
      checkOutput({tag, ":ctrl"}, {23'd0, dmemReq, pcEn, ifidEn, ifidFlush, idexEn,
                                   idexFlush, exmemEn, memwbFlush, errOut}, {23'd0, got.ctrl});
      checkOutput({tag, ":perfMem"},   perfMem,   got.pm);
      checkOutput({tag, ":perfLu"},    perfLu,    got.pl);
      checkOutput({tag, ":perfFlush"}, perfFlush, got.pf);
    end

    if (s.rst) begin
      mState = 0; mCnt = 0; mErr = 1'b0; mPm = '0; mPl = '0; mPf = '0;
    end else begin
      if (stall) mPm = mPm + 32'd1;
      if (luApp) mPl = mPl + 32'd1;
      if (brApp) mPf = mPf + 32'd1;
      case (mState)
        0: if (stall) begin mState = 1; mCnt = 1; end
        1: begin
          if (s.ack) mState = 0;
          else if (mCnt == TIMEOUT) begin mState = 2; mErr = 1'b1; end
          else mCnt++;
        end
        default: mState = 2;
      endcase
    end
  endtask

  initial begin
    stim_t idle;
    idle = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] starting pipe_hazard_ctrl bench");

    applyStimulus(mkStim(1, 1, 0, 1, 0, 0, 0, 0, 0, 0), "reset0");
    applyStimulus(mkStim(1, 1, 1, 0, 1, 3, 3, 0, 1, 0), "reset1");
    applyStimulus(idle, "idle");
    applyStimulus(mkStim(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "ackSame");
    applyStimulus(idle, "afterAckSame");

    for (int i = 0; i < 3; i++) applyStimulus(mkStim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "memWait");
    applyStimulus(mkStim(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "memAck");
    applyStimulus(idle, "afterMem");

    applyStimulus(mkStim(0, 0, 0, 0, 1, 5, 0, 5, 0, 1), "loadUseRs2");
    applyStimulus(idle, "afterLoadUse");
    applyStimulus(mkStim(0, 0, 0, 0, 1, 0, 0, 0, 0, 1), "rdZero");
    applyStimulus(mkStim(0, 0, 0, 0, 1, 7, 7, 3, 1, 1), "loadUseRs1");
    applyStimulus(mkStim(0, 0, 0, 0, 1, 7, 7, 3, 0, 1), "noUseFlag");
    applyStimulus(mkStim(0, 0, 0, 0, 0, 5, 0, 5, 0, 1), "notLoad");

    applyStimulus(mkStim(0, 0, 0, 1, 1, 5, 0, 5, 0, 1), "brOverLu");
    applyStimulus(idle, "afterBr");

    applyStimulus(mkStim(0, 1, 0, 1, 1, 5, 0, 5, 0, 1), "brStall0");
    applyStimulus(mkStim(0, 1, 0, 1, 0, 0, 0, 0, 0, 0), "brStall1");
    applyStimulus(mkStim(0, 1, 1, 1, 0, 0, 0, 0, 0, 0), "brAck");
    applyStimulus(idle, "afterBrAck");

    for (int i = 0; i < 5; i++) applyStimulus(mkStim(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "toWait");
    applyStimulus(mkStim(0, 1, 1, 1, 0, 0, 0, 0, 0, 0), "errHold0");
    applyStimulus(mkStim(0, 0, 0, 0, 1, 2, 2, 0, 1, 0), "errHold1");
    applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "errReset");
    applyStimulus(idle, "postReset");

    for (int i = 0; i < 80; i++) begin
      stim_t r;
      r = mkStim(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      applyStimulus(r, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
